// File: rtl/main_buff_ctrl_if.sv
// main_buff_ctrl_if: control, memory-read and buffer/column bus of the main buffer sequencer.
// Rev 1.0
`default_nettype none

interface main_buff_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] img_base;
  logic [3:0]        passes;
  logic              busy;
  logic              done;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic              buff_wr_en;
  logic [5:0]        buff_addr;
  logic              col_valid;
  logic              col_ready;
  logic              col_last;
  logic [3:0]        pass_idx;

  modport master (
    input  start, img_base, passes, mem_rd_valid, col_ready,
    output busy, done, mem_rd_req, mem_rd_addr, buff_wr_en, buff_addr,
           col_valid, col_last, pass_idx
  );

  modport slave (
    output start, img_base, passes, mem_rd_valid, col_ready,
    input  busy, done, mem_rd_req, mem_rd_addr, buff_wr_en, buff_addr,
           col_valid, col_last, pass_idx
  );
endinterface

`default_nettype wire

// File: rtl/main_buff_ctrl.sv
// main_buff_ctrl: loads one image tile into the main buffer, then sweeps its columns for N passes.
// Rev 1.0
`default_nettype none

module main_buff_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 16,
  parameter int COLS   = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  main_buff_ctrl_if.master bus
);

  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RCW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(WORDS - 1);
  localparam logic [RCW-1:0] C_LAST = RCW'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        passes_q, passes_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic [3:0]        pass_idx_q, pass_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              colv_q, colv_d;

  logic [3:0] pass_max;
  logic       last_pass;

  // A latched pass count of zero still performs a single sweep.
  assign pass_max  = (passes_q == 4'd0) ? 4'd1 : passes_q;
  assign last_pass = ({1'b0, pass_idx_q} + 5'd1) >= {1'b0, pass_max};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    passes_d   = passes_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    pass_idx_d = pass_idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d     = bus.img_base;
          passes_d   = bus.passes;
          wcnt_d     = '0;
          rcnt_d     = '0;
          pass_idx_d = 4'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.mem_rd_valid) begin
          if (wcnt_q == W_LAST) begin
            wcnt_d  = '0;
            state_d = S_STREAM;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      S_STREAM: begin
        if (colv_q && bus.col_ready) begin
          if (rcnt_q == C_LAST) begin
            rcnt_d = '0;
            if (last_pass) begin
              state_d = S_DONE;
            end else begin
              pass_idx_d = pass_idx_q + 4'd1;
            end
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_LOAD);
    colv_d = (state_d == S_STREAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      passes_q   <= 4'd0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      pass_idx_q <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      colv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      passes_q   <= passes_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      pass_idx_q <= pass_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
      colv_q     <= colv_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_rd_req  = req_q;
  assign bus.mem_rd_addr = req_q ? (base_q + ADDR_W'(wcnt_q)) : '0;
  // The write strobe follows the returning data in the same cycle.
  assign bus.buff_wr_en  = req_q & bus.mem_rd_valid;
  assign bus.buff_addr   = req_q  ? 6'(wcnt_q) :
                           colv_q ? 6'(rcnt_q) : 6'd0;
  assign bus.col_valid   = colv_q;
  assign bus.col_last    = colv_q && (rcnt_q == C_LAST);
  assign bus.pass_idx    = pass_idx_q;

  a_wr_only_load : assert property (@(posedge clk) disable iff (rst)
    bus.buff_wr_en |-> (state_q == S_LOAD));
  a_col_only_stream : assert property (@(posedge clk) disable iff (rst)
    bus.col_valid |-> (state_q == S_STREAM));
  a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
    bus.done |=> !bus.done);

endmodule

`default_nettype wire
